// File: rtl/multi_push_fifo.sv
// Circular FIFO accepting up to MULTI_PUSH entries per cycle, popping one; show-ahead head.
// Latency: a pushed entry is visible on data_out the cycle after it is written (no bypass).
// Backpressure: a push larger than space_cnt is dropped whole and flags overflow.
module multi_push_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MULTI_PUSH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [$clog2(MULTI_PUSH):0]          push_cnt,
    input  logic [MULTI_PUSH-1:0][DATA_WIDTH-1:0] data_in,
    output logic [$clog2(MULTI_PUSH):0]          space_cnt,
    input  logic                                 pop,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 empty,
    output logic                                 full,
    output logic [$clog2(DEPTH):0]               count,
    output logic                                 overflow,
    output logic                                 underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MULTI_PUSH) + 1;
    localparam int CW = AW + 1;

    logic [AW-1:0]         w_ptr;
    logic [AW-1:0]         r_ptr;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         free_cnt;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Space is judged on start-of-cycle occupancy; a same-cycle pop does not make room.
    assign free_cnt  = CW'(DEPTH) - occ;
    assign space_cnt = (free_cnt >= CW'(MULTI_PUSH)) ? PW'(MULTI_PUSH) : PW'(free_cnt);
    assign push_ok   = (push_cnt != '0) && (push_cnt <= space_cnt);
    assign pop_ok    = pop && (occ != '0);

    assign empty    = (occ == '0);
    assign full     = (occ == CW'(DEPTH));
    assign count    = occ;
    assign data_out = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                w_ptr <= w_ptr + AW'(push_cnt);
            end
            if (pop_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
            occ <= occ + (push_ok ? CW'(push_cnt) : '0) - CW'(pop_ok);
            if (push_cnt > space_cnt) begin
                overflow <= 1'b1;
            end
            if (pop && (occ == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; pointer wrap comes from the AW-bit index arithmetic.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            for (int i = 0; i < MULTI_PUSH; i++) begin
                if (i < int'(push_cnt)) begin
                    mem[w_ptr + AW'(i)] <= data_in[i];
                end
            end
        end
    end
endmodule

// File: doc/multi_push_fifo.md
MULTI_PUSH_FIFO -- requirements
Module: multi_push_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 SHALL have parameter MULTI_PUSH, default 2, max entries written per cycle; 1 <= MULTI_PUSH <= DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-006 SHALL have port push_cnt  input  $clog2(MULTI_PUSH)+1  entries offered this cycle.
REQ-007 SHALL have port data_in  input  DATA_WIDTH x MULTI_PUSH array  entries; data_in[0] oldest.
REQ-008 SHALL have port space_cnt  output  $clog2(MULTI_PUSH)+1  min(free entries, MULTI_PUSH).
REQ-009 SHALL have port pop  input  1  consume head entry this cycle.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  head entry, show-ahead.
REQ-011 SHALL have port empty  output  1  occupancy == 0.
REQ-012 SHALL have port full  output  1  occupancy == DEPTH.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: a push was rejected.
REQ-015 SHALL have port underflow  output  1  sticky: a pop hit an empty FIFO.

Function
REQ-016 SHALL hold write pointer, read pointer ($clog2(DEPTH) bits, modulo-DEPTH wrap) and occupancy register (0..DEPTH); full capacity DEPTH usable, no sacrificial slot.
REQ-017 SHALL, on accepted push, write data_in[i] to slot (w_ptr+i) mod DEPTH for i in 0..push_cnt-1 and advance w_ptr by push_cnt in the same edge.
REQ-018 SHALL accept push iff push_cnt <= space_cnt; push_cnt == 0 is a no-op.
REQ-019 SHALL compute space_cnt from occupancy at start of cycle; same-cycle pop SHALL NOT increase space_cnt.
REQ-020 SHALL, when push_cnt > space_cnt, drop the whole push (no partial write, w_ptr unchanged) and set overflow on that edge.
REQ-021 SHALL drive data_out combinationally from slot r_ptr; value undefined-but-stable (last slot content) when empty.
REQ-022 SHALL, on pop with occupancy > 0, advance r_ptr by 1; data_out shows next entry the following cycle.
REQ-023 SHALL, on pop with occupancy == 0, leave r_ptr unchanged and set underflow; same-cycle push into empty FIFO SHALL NOT be popped (no bypass; 1-cycle write-to-read latency).
REQ-024 SHALL update occupancy as occupancy + accepted_push_cnt - accepted_pop each edge, never leaving 0..DEPTH.
REQ-025 SHALL handle write wrap: push of 2 at w_ptr == DEPTH-1 writes slots DEPTH-1 and 0, w_ptr becomes 1.
REQ-026 SHALL keep overflow/underflow set until reset; no other clear path.
REQ-027 SHALL derive empty, full, count, space_cnt combinationally from occupancy only.

Reset
REQ-028 SHALL, on any edge with rst == 0, clear w_ptr, r_ptr, occupancy, overflow, underflow, overriding push/pop that cycle.
REQ-029 SHALL show after reset: empty=1, full=0, count=0, space_cnt=MULTI_PUSH, overflow=0, underflow=0.
REQ-030 SHALL not reset storage array; contents pre-write are don't-care.
REQ-031 SHALL, on reset mid-operation, discard all stored entries; first post-reset push lands in slot 0.

Verification (DEPTH=8, DATA_WIDTH=8, MULTI_PUSH=2)
REQ-032 SHALL cover: push_cnt=2 data {0x11,0x22}, next cycle -> count=2, data_out=0x11; pop -> data_out=0x22 next cycle, count=1.
REQ-033 SHALL cover: fill to 7, push_cnt=2 -> rejected, count stays 7, overflow=1; push_cnt=1 -> count=8, full=1, space_cnt=0.
REQ-034 SHALL cover: empty FIFO, pop=1 with push_cnt=1 0xAA -> underflow=1, count=1, data_out=0xAA next cycle.
REQ-035 SHALL cover: count=8 with pop=1 and push_cnt=1 same cycle -> push rejected (space_cnt=0), overflow=1, count=7.
REQ-036 SHALL cover wrap: 7 single pushes + 7 pops, then push_cnt=2 {0x5A,0xA5} -> slots 7,0 written, pops return 0x5A then 0xA5, empty=1.
REQ-037 SHALL cover: count=5, overflow=1, rst=0 one cycle -> count=0, empty=1, overflow=0, space_cnt=2.
